// File: rtl/f2c_pkg.sv
// f2c_pkg: shared constants, state type and width helper for the Fahrenheit-to-Celsius converter
package f2c_pkg;
   localparam int F2C_OFFSET = 32;
   localparam int F2C_MUL    = 5;
   localparam int F2C_DIV    = 9;
   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} f2c_state_t;
   function automatic int f2c_qw(input int width);
      return width + 3;
   endfunction
endpackage

// File: rtl/seq_div_const.sv
// seq_div_const: restoring divide by a constant, one quotient bit per clock, MSB first
// quotient/remainder show the result of the step in flight and are final while done is high
module seq_div_const #(
   parameter int N = 11,
   parameter int DIVISOR = 9,
   localparam int RW = $clog2(DIVISOR),
   localparam int CW = $clog2(N + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [N-1:0]  dividend,
   output logic          busy,
   output logic          done,
   output logic [N-1:0]  quotient,
   output logic [RW-1:0] remainder
);
   logic [N-1:0] d_q, d_d, q_q, q_d;
   logic [RW-1:0] r_q, r_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [RW:0] trial, sub;
   logic ge;
   assign trial = {r_q, d_q[N-1]};
   assign sub = trial - (RW+1)'(DIVISOR);
   assign ge = trial >= (RW+1)'(DIVISOR);
   assign quotient = {q_q[N-2:0], ge};
   assign remainder = ge ? sub[RW-1:0] : trial[RW-1:0];
   assign busy = cnt_q != '0;
   assign done = cnt_q == CW'(1);
   always_comb begin
      cnt_d = start ? CW'(N) : busy ? cnt_q - CW'(1) : cnt_q;
      d_d = start ? dividend : busy ? d_q << 1 : d_q;
      q_d = start ? '0 : busy ? quotient : q_q;
      r_d = start ? '0 : busy ? remainder : r_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         d_q <= '0;
         q_q <= '0;
         r_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         d_q <= d_d;
         q_q <= q_d;
         r_q <= r_d;
      end
   end
endmodule

// File: rtl/fahr_to_cels_seq.sv
// fahr_to_cels_seq: C = (F-32)*5/9 via shift-add multiply and sequential divide; F2C_ROUND_EN rounds half away from zero
module fahr_to_cels_seq
   import f2c_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] fahr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   cels
);
   localparam int QW = f2c_qw(WIDTH);
   f2c_state_t state_q, state_d;
   logic sign_q, sign_d;
   logic [WIDTH-1:0] mag_q, mag_d;
   logic [WIDTH:0] cels_q, cels_d, diff, cels_n;
   logic [QW-1:0] prod, q, qr;
   logic [3:0] r;
   logic start, busy, done;
   logic unused_bits;
   assign diff = {1'b0, fahr} - (WIDTH+1)'(F2C_OFFSET);
   assign prod = ({3'b0, mag_q} << 2) + {3'b0, mag_q};
`ifdef F2C_ROUND_EN
   assign qr = q + QW'({r, 1'b0} >= 5'(F2C_DIV));
   assign unused_bits = ^{busy, qr[QW-1:WIDTH+1]};
`else
   assign qr = q;
   assign unused_bits = ^{busy, qr[QW-1:WIDTH+1], r};
`endif
   assign cels_n = sign_q ? -qr[WIDTH:0] : qr[WIDTH:0];
   assign cels = cels_q;
   seq_div_const #(.N(QW), .DIVISOR(F2C_DIV)) u_div (
      .clk(clk),
      .rst(rst),
      .start(start),
      .dividend(prod),
      .busy(busy),
      .done(done),
      .quotient(q),
      .remainder(r)
   );
   always_comb begin
      state_d = state_q;
      sign_d = sign_q;
      mag_d = mag_q;
      cels_d = cels_q;
      start = 1'b0;
      in_ready = (state_q == IDLE) && !rst;
      out_valid = state_q == DONE;
      unique case (state_q)
         IDLE: if (in_valid && in_ready) begin
            state_d = MUL;
            sign_d = diff[WIDTH];
            mag_d = diff[WIDTH] ? WIDTH'(-diff) : diff[WIDTH-1:0];
         end
         MUL: begin
            start = 1'b1;
            state_d = DIV;
         end
         DIV: if (done) begin
            state_d = DONE;
            cels_d = cels_n;
         end
         DONE: if (out_ready) state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sign_q <= 1'b0;
         mag_q <= '0;
         cels_q <= '0;
      end else begin
         state_q <= state_d;
         sign_q <= sign_d;
         mag_q <= mag_d;
         cels_q <= cels_d;
      end
   end
endmodule

// File: tb/tb_fahr_to_cels_seq.sv
// tb_fahr_to_cels_seq: directed vectors, backpressure, back-to-back, abort and full sweep for fahr_to_cels_seq
module tb_fahr_to_cels_seq;
`ifdef F2C_ROUND_EN
   localparam int RND = 1;
`else
   localparam int RND = 0;
`endif
   logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
   logic in_ready, out_valid;
   logic [7:0] fahr = '0;
   logic [8:0] cels;
   int nvec = 0, nerr = 0;
   typedef struct { logic [7:0] f; int et; int er; } vec_t;
   vec_t vt[11];
   always #5 clk = ~clk;
   fahr_to_cels_seq #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .fahr(fahr),
      .out_valid(out_valid), .out_ready(out_ready), .cels(cels)
   );
   task automatic chk(input string nm, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask
   function automatic int ref_c(input int f);
      int d, m, q;
      d = f - 32;
      m = d < 0 ? -d : d;
      q = m * 5 / 9 + ((RND == 1 && 2 * (m * 5 % 9) >= 9) ? 1 : 0);
      return d < 0 ? -q : q;
   endfunction
   task automatic run(input logic [7:0] f, input int exp, input int hold);
      int lat;
      in_valid = 1'b1;
      fahr = f;
      for (int i = 0; i < 40 && !in_ready; i++) begin @(posedge clk); #1; end
      chk("accept_ready", int'(in_ready), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      fahr = f ^ 8'h5A;
      out_ready = hold == 0;
      lat = 0;
      while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
      chk("latency", lat, 12);
      chk("cels", $signed(cels), exp);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("bp_valid", int'(out_valid), 1);
         chk("bp_cels", $signed(cels), exp);
         chk("bp_in_ready", int'(in_ready), 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("release_valid", int'(out_valid), 0);
      chk("release_in_ready", int'(in_ready), 1);
   endtask
   initial begin
      int acc[4], res[4];
      int acc_n, res_n, seen;
      vt[0] = '{8'd212, 100, 100};
      vt[1] = '{8'd50, 10, 10};
      vt[2] = '{8'd32, 0, 0};
      vt[3] = '{8'd0, -17, -18};
      vt[4] = '{8'd255, 123, 124};
      vt[5] = '{8'd41, 5, 5};
      vt[6] = '{8'd100, 37, 38};
      vt[7] = '{8'd33, 0, 1};
      vt[8] = '{8'd31, 0, -1};
      vt[9] = '{8'd1, -17, -17};
      vt[10] = '{8'd98, 36, 37};
      in_valid = 1'b1;
      fahr = 8'd212;
      repeat (2) begin @(posedge clk); #1; end
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_cels", int'(cels), 0);
      rst = 1'b0;
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_idle", int'(in_ready), 1);
      chk("post_rst_no_valid", int'(out_valid), 0);
      for (int i = 0; i < 11; i++) run(vt[i].f, RND == 1 ? vt[i].er : vt[i].et, 0);
      run(8'd98, RND == 1 ? 37 : 36, 5);
      acc_n = 0;
      res_n = 0;
      in_valid = 1'b1;
      fahr = 8'd212;
      for (int c = 0; c < 60 && res_n < 2; c++) begin
         if (in_valid && in_ready && acc_n < 4) acc[acc_n++] = c;
         if (out_valid && res_n < 4) res[res_n++] = $signed(cels);
         @(posedge clk); #1;
         if (acc_n == 1) fahr = 8'd41;
         if (acc_n == 2) begin fahr = 8'd0; in_valid = 1'b0; end
      end
      in_valid = 1'b0;
      chk("b2b_accepts", acc_n, 2);
      chk("b2b_interval", acc_n == 2 ? acc[1] - acc[0] : -1, 14);
      chk("b2b_results", res_n, 2);
      chk("b2b_first", res_n > 0 ? res[0] : -999, 100);
      chk("b2b_second", res_n > 1 ? res[1] : -999, 5);
      @(posedge clk); #1;
      in_valid = 1'b1;
      fahr = 8'd212;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_in_ready", int'(in_ready), 0);
      chk("abort_out_valid", int'(out_valid), 0);
      chk("abort_cels", int'(cels), 0);
      rst = 1'b0;
      seen = 0;
      repeat (20) begin @(posedge clk); #1; if (out_valid) seen++; end
      chk("abort_no_result", seen, 0);
      chk("abort_cels_held", int'(cels), 0);
      run(8'd212, 100, 0);
      for (int f = 0; f < 256; f++) run(8'(f), ref_c(f), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/fahr_to_cels_seq.md
# fahr_to_cels_seq

Sequential Fahrenheit-to-Celsius converter, the inverse of the team's Celsius-to-Fahrenheit conversion routine. It computes C = (F − 32) × 5 / 9 with a one-multiply step followed by a multi-cycle restoring divide. The block sits between a temperature-sample producer and a consumer, using valid/ready handshakes on both sides. It handles one transaction at a time.

## Interface
- WIDTH, 8: bit width of the unsigned Fahrenheit input; must be ≥ 6.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer presents `fahr`.
- in_ready  output  1  block can accept; high only in IDLE and when `rst` = 0.
- fahr  input  WIDTH  unsigned Fahrenheit sample.
- out_valid  output  1  `cels` is valid; held until accepted.
- out_ready  input  1  consumer accepts `cels`.
- cels  output  WIDTH+1  signed two's-complement Celsius result.

## Operation
- States: IDLE, MUL, DIV, DONE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid && in_ready`:
    - register diff = fahr − 32 (WIDTH+1 signed);
    - store sign = diff < 0 and mag = |diff|;
    - go to MUL.
- **MUL**
  - prod = mag × 5, computed as (mag<<2) + mag, width WIDTH+3.
  - Load the divide counter with WIDTH+3.
  - Go to DIV.
- **DIV**
  - One restoring-division step per cycle, divisor 9, MSB first.
  - Partial remainder is 4 bits wide plus 1 guard bit.
  - After WIDTH+3 steps: quotient q (WIDTH+3 bits, value < 2^WIDTH) and remainder r (0..8).
  - Go to DONE.
- **DONE**
  - `out_valid` = 1.
  - `cels` = sign ? −q : q, truncated to WIDTH+1 bits.
  - Without rounding, the result rounds toward zero.
  - On `out_valid && out_ready`: go to IDLE.
- Arithmetic: the magnitude never exceeds 2^WIDTH. The product fits WIDTH+3 bits and the quotient fits WIDTH bits, so there is no overflow and `cels` cannot saturate.
- Backpressure: with `out_ready` low, `cels` and `out_valid` stay stable indefinitely and `in_ready` stays 0.
- Input `fahr` is sampled only at the accept edge; later changes are ignored.
- Reset:
  - `rst` forces IDLE and clears diff, prod, q, r, sign and the counter.
  - Outputs go to `in_ready` = 0 (while `rst` = 1), `out_valid` = 0, `cels` = 0.
  - A reset in any state aborts the transaction; no result is emitted.
- If `rst` and `in_valid` are high on the same edge, reset wins and nothing is accepted.

## Timing
- Acceptance edge = k.
- MUL occupies the cycle after k.
- DIV steps occur on edges k+2 … k+WIDTH+4.
- `out_valid` rises after edge k+WIDTH+4: a latency of WIDTH+4 clocks (12 for WIDTH = 8).
- With `out_ready` tied high:
  - output handshake at edge k+WIDTH+5;
  - `in_ready` high in the following cycle;
  - minimum issue interval WIDTH+6 clocks (14 for WIDTH = 8).
- `cels` changes only on entry to DONE; it is 0 after reset and holds its last value in IDLE.

## Configuration
- F2C_ROUND_EN defined:
  - in DONE, if 2·r ≥ 9 then q is incremented before the sign is applied (round half away from zero);
  - adds one comparator and an incrementer; latency unchanged.
- F2C_ROUND_EN undefined: the result rounds toward zero (truncation), and r is unused except for debug.

## Structure
- Package `f2c_pkg` holds:
  - F2C_OFFSET = 32, F2C_MUL = 5, F2C_DIV = 9;
  - state typedef `f2c_state_t` (IDLE, MUL, DIV, DONE);
  - a localparam function for the quotient width (WIDTH+3).
- Sub-module `seq_div_const` is a restoring divider, one bit per cycle.
  - Parameters: dividend width, divisor.
  - Ports: clk, rst, start, dividend, busy, done, quotient, remainder.
  - The FSM in `fahr_to_cels_seq` sequences it.

## Test plan
- fahr = 212, `out_ready` high → `out_valid` 12 clocks after accept, `cels` = 100; fahr = 50 → 10; fahr = 32 → 0.
- fahr = 0 → `cels` = −17 (−18 with F2C_ROUND_EN); fahr = 255 → 123 (124 with F2C_ROUND_EN).
- Backpressure, fahr = 98:
  - hold `out_ready` low 5 cycles → `cels` = 36 stable, `out_valid` held, `in_ready` 0 throughout;
  - release → IDLE on the next cycle.
- Back-to-back with `in_valid` held high (fahr = 212, then 41):
  - accepts are 14 clocks apart;
  - results 100 then 5;
  - `fahr` changes between accepts are ignored.
- Reset at the 4th DIV cycle → `out_valid` never asserts, all outputs 0; next transaction fahr = 212 → 100 with normal latency.
- Exhaustive sweep over fahr 0…255 against a reference model of (F−32)×5/9 with the matching rounding mode → zero mismatches.
